// File: rtl/pc_fetch_seq_pkg.sv
// Shared types and constants for the fetch/PC sequencer.
package pc_fetch_seq_pkg;

  // Sequencer states: RST -> FETCH -> ISSUE -> FETCH ..., ISSUE -> HALT
  typedef enum logic [1:0] {
    FS_RST   = 2'd0,
    FS_FETCH = 2'd1,
    FS_ISSUE = 2'd2,
    FS_HALT  = 2'd3
  } fetchState_e;

  // Instruction presented to decode while nothing has been fetched yet
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Default PC after reset; any override must be even
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  // Instructions are 16 bits, so sequential flow advances by two bytes
  localparam logic [15:0] PC_STEP = 16'd2;

  // A fetch address is only legal on a halfword boundary
  function automatic logic isMisaligned(input logic [15:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/pc_fetch_seq_if.sv
// Bus bundle between the sequencer, instruction memory and the decoder.
// The master side is the sequencer; the slave side is memory plus decode.
interface pc_fetch_seq_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;

  logic [15:0] Instr;
  logic        InstrValid;
  logic        InstrAck;
  logic        PcSel;
  logic        RegJmp;
  logic        Halt;
  logic [15:0] Imm;
  logic [15:0] RsVal;

  logic [15:0] Pc;
  logic [15:0] PcPlus2;
  logic        Halted;
  logic        FetchErr;

  modport master (
    output imem_req, imem_addr, Instr, InstrValid, Pc, PcPlus2, Halted, FetchErr,
    input  imem_rdata, imem_done, InstrAck, PcSel, RegJmp, Halt, Imm, RsVal
  );

  modport slave (
    input  imem_req, imem_addr, Instr, InstrValid, Pc, PcPlus2, Halted, FetchErr,
    output imem_rdata, imem_done, InstrAck, PcSel, RegJmp, Halt, Imm, RsVal
  );

endinterface

// File: rtl/pc_fetch_seq_pc_next_calc.sv
// Combinational next-PC selection: sequential, PC-relative or register jump.
// All adds wrap modulo 2^16; misalign flags an odd target.
module pc_next_calc
  import pc_fetch_seq_pkg::*;
(
  input  logic [15:0] pc_i,
  input  logic [15:0] imm_i,
  input  logic [15:0] rsVal_i,
  input  logic        pcSel_i,
  input  logic        regJmp_i,
  output logic [15:0] next_o,
  output logic [15:0] pcPlus2_o,
  output logic        misalign_o
);

  logic [15:0] branchTgt;
  logic [15:0] regTgt;

  assign pcPlus2_o  = pc_i + PC_STEP;
  assign branchTgt  = pcPlus2_o + imm_i;
  assign regTgt     = rsVal_i + imm_i;

  // Register jump beats PC-relative redirect, which beats fall-through
  always_comb begin
    next_o = pcPlus2_o;
    if (regJmp_i) begin
      next_o = regTgt;
    end else if (pcSel_i) begin
      next_o = branchTgt;
    end
  end

  assign misalign_o = isMisaligned(next_o);

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch/PC sequencer: owns the PC, fetches one instruction at a time over
// the req/done memory handshake, holds it for decode until acknowledged,
// then applies the decoder's redirect/halt decision.
module pc_fetch_seq
  import pc_fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
)
(
  input  logic           clk,
  input  logic           rst,
  pc_fetch_seq_if.master bus
);

  fetchState_e state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        instrValid_q, instrValid_d;
  logic        halted_q, halted_d;
  logic        fetchErr_q, fetchErr_d;
  logic        imemReq;

  logic [15:0] nextPc;
  logic [15:0] pcPlus2;
  logic        misalign;

  pc_next_calc u_nextCalc (
    .pc_i       (pc_q),
    .imm_i      (bus.Imm),
    .rsVal_i    (bus.RsVal),
    .pcSel_i    (bus.PcSel),
    .regJmp_i   (bus.RegJmp),
    .next_o     (nextPc),
    .pcPlus2_o  (pcPlus2),
    .misalign_o (misalign)
  );

  // State, PC and instruction registers; reset wins over any in-flight fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FS_RST;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      instrValid_q <= 1'b0;
      halted_q     <= 1'b0;
      fetchErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instrValid_q <= instrValid_d;
      halted_q     <= halted_d;
      fetchErr_q   <= fetchErr_d;
    end
  end

  // Next-state logic; completions and controls only matter in their own state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instrValid_d = instrValid_q;
    halted_d     = halted_q;
    fetchErr_d   = fetchErr_q;
    imemReq      = 1'b0;

    case (state_q)
      FS_RST: begin
        state_d = FS_FETCH;
      end

      FS_FETCH: begin
        imemReq = 1'b1;
        if (bus.imem_done) begin
          instr_d      = bus.imem_rdata;
          instrValid_d = 1'b1;
          state_d      = FS_ISSUE;
        end
      end

      FS_ISSUE: begin
        if (bus.InstrAck) begin
          instrValid_d = 1'b0;
          if (bus.Halt) begin
            halted_d = 1'b1;
            state_d  = FS_HALT;
          end else if (misalign) begin
            fetchErr_d = 1'b1;
            halted_d   = 1'b1;
            state_d    = FS_HALT;
          end else begin
            pc_d    = nextPc;
            state_d = FS_FETCH;
          end
        end
      end

      FS_HALT: begin
        state_d = FS_HALT;
      end

      default: begin
        state_d = FS_RST;
      end
    endcase
  end

  assign bus.imem_req   = imemReq;
  assign bus.imem_addr  = pc_q;
  assign bus.Instr      = instr_q;
  assign bus.InstrValid = instrValid_q;
  assign bus.Pc         = pc_q;
  assign bus.PcPlus2    = pcPlus2;
  assign bus.Halted     = halted_q;
  assign bus.FetchErr   = fetchErr_q;

endmodule
